// File: rtl/bank_people_counter.sv
// Bank occupancy front end: synchronises and debounces the entry/exit photocells,
// turns debounced rising edges into one-cycle count pulses and tracks a saturating occupancy.
module bank_people_counter #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_in,
  input  logic             sensor_out,
  input  logic             bank_open,
  output logic             up_count,
  output logic             down_count,
  output logic [CNT_W-1:0] pcount
);

  localparam int                CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX      = {CNT_W{1'b1}};

  // Index 0 is the entry sensor, index 1 the exit sensor.
  logic [1:0]         raw_s;
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_dly_q, deb_dly_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         event_s;
  logic               entry_ok_s;
  logic               up_count_q, up_count_d;
  logic               down_count_q, down_count_d;
  logic [CNT_W-1:0]   pcount_q, pcount_d;

  assign raw_s = {sensor_out, sensor_in};

  // Synchroniser shift and debounce filter; a level is accepted only after it holds DEB_CYCLES edges.
  always_comb begin
    sync1_d   = raw_s;
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = {CW{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  assign event_s    = deb_q & ~deb_dly_q;
  assign entry_ok_s = event_s[0] & bank_open;

  // Pulses come straight from events; pcount follows the pulses one cycle later
  // so the pulse cycle still shows the pre-update occupancy.
  always_comb begin
    up_count_d   = entry_ok_s & ~event_s[1];
    down_count_d = event_s[1] & ~entry_ok_s;
    if (up_count_q) begin
      if (pcount_q == MAX) begin
        pcount_d = pcount_q;
      end else begin
        pcount_d = pcount_q + CNT_W'(1);
      end
    end else if (down_count_q) begin
      if (pcount_q == {CNT_W{1'b0}}) begin
        pcount_d = pcount_q;
      end else begin
        pcount_d = pcount_q - CNT_W'(1);
      end
    end else begin
      pcount_d = pcount_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      deb_q        <= 2'b00;
      deb_dly_q    <= 2'b00;
      cnt_q        <= {2*CW{1'b0}};
      up_count_q   <= 1'b0;
      down_count_q <= 1'b0;
      pcount_q     <= {CNT_W{1'b0}};
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_dly_q    <= deb_dly_d;
      cnt_q        <= cnt_d;
      up_count_q   <= up_count_d;
      down_count_q <= down_count_d;
      pcount_q     <= pcount_d;
    end
  end

  assign up_count   = up_count_q;
  assign down_count = down_count_q;
  assign pcount     = pcount_q;

endmodule
